// File: rtl/shift_word_collector.sv
// shift_word_collector: rebuilds parallel words from a serial bit stream.
// Completed words are queued in a small FIFO behind a valid/ready handshake. Revision 1.0
`default_nettype none

module shift_word_collector #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 2,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       Clock,
  input  logic                       Aclr,
  input  logic                       BitIn,
  input  logic                       BitValid,
  input  logic                       Clear,
  output logic [WIDTH-1:0]           WordOut,
  output logic                       WordValid,
  input  logic                       WordReady,
  output logic [$clog2(WIDTH)-1:0]   BitCount,
  output logic [$clog2(DEPTH):0]     FillLevel,
  output logic                       Overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [PW:0]   FULL_LVL = (PW + 1)'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, ASSEMBLING = 1'b1} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  asm_reg, asm_next, shifted;
  logic [CW-1:0]     count_next;
  logic              push;

  always_ff @(posedge Clock or posedge Aclr) begin
    if (Aclr) begin
      state    <= IDLE;
      asm_reg  <= '0;
      BitCount <= '0;
    end else begin
      state    <= state_next;
      asm_reg  <= asm_next;
      BitCount <= count_next;
    end
  end

  // Clear outranks BitValid, so a bit on a Clear edge never completes a word.
  always_comb begin
    shifted    = LSB_FIRST ? {BitIn, asm_reg[WIDTH-1:1]} : {asm_reg[WIDTH-2:0], BitIn};
    state_next = state;
    asm_next   = asm_reg;
    count_next = BitCount;
    push       = 1'b0;
    if (Clear) begin
      state_next = IDLE;
      asm_next   = '0;
      count_next = '0;
    end else if (BitValid) begin
      asm_next = shifted;
      if (BitCount == LAST_BIT) begin
        push       = 1'b1;
        count_next = '0;
        state_next = IDLE;
      end else begin
        count_next = BitCount + 1'b1;
        state_next = ASSEMBLING;
      end
    end
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, rd_next;
  logic [PW:0]      fill_next;
  logic [WIDTH-1:0] out_next;
  logic             pop, full, accept, drop;

  always_comb begin
    pop     = WordValid && WordReady;
    full    = (FillLevel == FULL_LVL);
    accept  = push && (!full || pop);
    drop    = push && full && !pop;
    rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;
    case ({accept, pop})
      2'b10:   fill_next = FillLevel + 1'b1;
      2'b01:   fill_next = FillLevel - 1'b1;
      default: fill_next = FillLevel;
    endcase
    // The new head is the incoming word when it lands in the slot the read pointer moves to.
    out_next = (accept && (rd_next == wr_ptr)) ? shifted : mem[rd_next];
  end

  always_ff @(posedge Clock) begin
    if (accept) mem[wr_ptr] <= shifted;
  end

  always_ff @(posedge Clock or posedge Aclr) begin
    if (Aclr) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      FillLevel <= '0;
      WordOut   <= '0;
      Overflow  <= 1'b0;
    end else begin
      rd_ptr    <= rd_next;
      FillLevel <= fill_next;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (fill_next != '0) WordOut <= out_next;
      if (Clear) Overflow <= 1'b0;
      else if (drop) Overflow <= 1'b1;
    end
  end

  assign WordValid = (FillLevel != '0);

endmodule

`default_nettype wire

// File: tb/tb_shift_word_collector.sv
// Directed bench for shift_word_collector with a scoreboard of expected words.
`default_nettype none

module tb_shift_word_collector;

  logic        Clock = 1'b0;
  logic        Aclr = 1'b1;
  logic        BitIn = 1'b0, BitValid = 1'b0, Clear = 1'b0, WordReady = 1'b0;
  logic [15:0] WordOut;
  logic        WordValid, Overflow;
  logic [3:0]  BitCount;
  logic [1:0]  FillLevel;

  logic        m_bit = 1'b0, m_valid = 1'b0, m_ready = 1'b0;
  logic [15:0] m_word;
  logic        m_wvalid, m_ovf;
  logic [3:0]  m_count;
  logic [1:0]  m_fill;

  int compared = 0;
  int mismatched = 0;
  logic [15:0] sb[$];
  logic [15:0] sb_m[$];

  always #5 Clock = ~Clock;

  shift_word_collector #(.WIDTH(16), .DEPTH(2), .LSB_FIRST(1'b1)) dut (
    .Clock(Clock), .Aclr(Aclr), .BitIn(BitIn), .BitValid(BitValid), .Clear(Clear),
    .WordOut(WordOut), .WordValid(WordValid), .WordReady(WordReady),
    .BitCount(BitCount), .FillLevel(FillLevel), .Overflow(Overflow));

  shift_word_collector #(.WIDTH(16), .DEPTH(2), .LSB_FIRST(1'b0)) dut_msb (
    .Clock(Clock), .Aclr(Aclr), .BitIn(m_bit), .BitValid(m_valid), .Clear(1'b0),
    .WordOut(m_word), .WordValid(m_wvalid), .WordReady(m_ready),
    .BitCount(m_count), .FillLevel(m_fill), .Overflow(m_ovf));

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [15:0] w, input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      BitIn = w[i];
      BitValid = 1'b1;
      tick();
      BitValid = 1'b0;
      if (gapped) begin
        tick();
        chk("gap_hold", {28'd0, BitCount}, i + 1);
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w, input bit gapped, input bit accepted);
    send_bits(w, 15, gapped);
    chk("count_pre_last", {28'd0, BitCount}, 32'd15);
    BitIn = w[15];
    BitValid = 1'b1;
    if (accepted) sb.push_back(w);
    tick();
    BitValid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] exp;
    exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
    chk({tag, "_valid"}, {31'd0, WordValid}, 32'd1);
    chk(tag, {16'd0, WordOut}, {16'd0, exp});
    WordReady = 1'b1;
    tick();
    WordReady = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    repeat (2) @(posedge Clock);
    #1 Aclr = 1'b0;
    tick();

    // Asynchronous reset mid-word and mid-pop
    send_word(16'h00FF, 1'b0, 1'b1);
    chk("pre_rst_word", {16'd0, WordOut}, 32'h00FF);
    send_bits(16'h001F, 5, 1'b0);
    chk("pre_rst_count", {28'd0, BitCount}, 32'd5);
    WordReady = 1'b1;
    #2 Aclr = 1'b1;
    #1;
    chk("rst_word", {16'd0, WordOut}, 32'd0);
    chk("rst_valid", {31'd0, WordValid}, 32'd0);
    chk("rst_count", {28'd0, BitCount}, 32'd0);
    chk("rst_fill", {30'd0, FillLevel}, 32'd0);
    chk("rst_ovf", {31'd0, Overflow}, 32'd0);
    sb.delete();
    WordReady = 1'b0;
    #1 Aclr = 1'b0;
    tick();

    // Contiguous LSB-first word
    send_word(16'hA5C3, 1'b0, 1'b1);
    chk("a5c3_word", {16'd0, WordOut}, 32'hA5C3);
    chk("a5c3_fill", {30'd0, FillLevel}, 32'd1);
    chk("a5c3_count", {28'd0, BitCount}, 32'd0);
    pop_check("a5c3_pop");
    chk("a5c3_empty", {31'd0, WordValid}, 32'd0);

    // Gapped BitValid
    send_word(16'h1234, 1'b1, 1'b1);
    pop_check("gap_pop");

    // Overflow: third word dropped
    send_word(16'h0001, 1'b0, 1'b1);
    send_word(16'h0002, 1'b0, 1'b1);
    send_word(16'h0003, 1'b0, 1'b0);
    chk("ovf_fill", {30'd0, FillLevel}, 32'd2);
    chk("ovf_flag", {31'd0, Overflow}, 32'd1);
    pop_check("ovf_pop1");
    pop_check("ovf_pop2");
    chk("ovf_empty", {31'd0, WordValid}, 32'd0);
    chk("ovf_sticky", {31'd0, Overflow}, 32'd1);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("clr_ovf", {31'd0, Overflow}, 32'd0);

    // Push and pop on the same edge while full
    send_word(16'h00AA, 1'b0, 1'b1);
    send_word(16'h00BB, 1'b0, 1'b1);
    send_bits(16'h00CC, 15, 1'b0);
    chk("pp_head", {16'd0, WordOut}, {16'd0, sb.pop_front()});
    BitIn = 1'b0;
    BitValid = 1'b1;
    WordReady = 1'b1;
    sb.push_back(16'h00CC);
    tick();
    BitValid = 1'b0;
    WordReady = 1'b0;
    chk("pp_fill", {30'd0, FillLevel}, 32'd2);
    chk("pp_ovf", {31'd0, Overflow}, 32'd0);
    pop_check("pp_pop_bb");
    pop_check("pp_pop_cc");

    // Clear has priority over a final bit
    send_word(16'h1111, 1'b0, 1'b1);
    send_word(16'h2222, 1'b0, 1'b1);
    send_word(16'h3333, 1'b0, 1'b0);
    chk("cp_ovf_set", {31'd0, Overflow}, 32'd1);
    send_bits(16'hFFFF, 15, 1'b0);
    BitIn = 1'b1;
    BitValid = 1'b1;
    Clear = 1'b1;
    tick();
    BitValid = 1'b0;
    Clear = 1'b0;
    chk("cp_count", {28'd0, BitCount}, 32'd0);
    chk("cp_ovf", {31'd0, Overflow}, 32'd0);
    chk("cp_fill", {30'd0, FillLevel}, 32'd2);
    pop_check("cp_pop1");
    pop_check("cp_pop2");
    send_word(16'h8001, 1'b0, 1'b1);
    pop_check("cp_8001");
    chk("cp_sb_empty", sb.size(), 32'd0);

    // MSB-first instance
    sb_m.push_back(16'h8000);
    sb_m.push_back(16'h1234);
    for (int k = 0; k < 2; k++) begin
      w = sb_m[k];
      for (int i = 0; i < 16; i++) begin
        m_bit = w[15 - i];
        m_valid = 1'b1;
        tick();
      end
      m_valid = 1'b0;
    end
    chk("msb_fill", {30'd0, m_fill}, 32'd2);
    chk("msb_count", {28'd0, m_count}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      chk("msb_valid", {31'd0, m_wvalid}, 32'd1);
      chk("msb_word", {16'd0, m_word}, {16'd0, sb_m.pop_front()});
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    chk("msb_empty", {31'd0, m_wvalid}, 32'd0);
    chk("msb_ovf", {31'd0, m_ovf}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
